// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and status-state encoding for the 8-entry FIFO controller.
// FIFO_SIMUL_RW_EN adds the RW state used when a read and a write are both accepted.
package fifo_ctrl_pkg;

   localparam int unsigned FIFO_AW    = 3;
   localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {
      INIT,
      NO_OP,
      WRITE,
      WR_ERR,
      READ,
      RD_ERR
`ifdef FIFO_SIMUL_RW_EN
      , RW
`endif
   } fifo_state_e;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer with synchronous active-high reset and increment enable.
module fifo_ptr
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned AW = FIFO_AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc_i,
   output logic [AW-1:0] ptr_o
);

   logic [AW-1:0] ptr_q, ptr_d;

   // Natural binary overflow gives the 7 -> 0 wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) ptr_d = ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// Control stage for the 8-entry register-file FIFO: strobes, pointers, occupancy, status.
// Define FIFO_SIMUL_RW_EN to accept a simultaneous read and write in the same cycle.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned AW = FIFO_AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic          rd_en,
   output logic          we,
   output logic [AW-1:0] wAddr,
   output logic          re,
   output logic [AW-1:0] rAddr,
   output logic [AW:0]   data_count,
   output logic          full,
   output logic          empty,
   output logic          wr_ack,
   output logic          wr_err,
   output logic          rd_ack,
   output logic          rd_err
);

   localparam int unsigned CW    = AW + 1;
   localparam int unsigned DEPTH = 1 << AW;

   fifo_state_e   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
   logic          wr_ack_d, wr_err_d, rd_ack_d, rd_err_d;
   logic          both;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign both  = wr_en & rd_en;

   // Strobes go out in the request cycle; reset always wins.
`ifdef FIFO_SIMUL_RW_EN
   assign we = wr_en & ~full  & ~reset;
   assign re = rd_en & ~empty & ~reset;
`else
   assign we = wr_en & ~rd_en & ~full  & ~reset;
   assign re = rd_en & ~wr_en & ~empty & ~reset;
`endif

   fifo_ptr #(.AW(AW)) u_tail (
      .clk   (clk),
      .reset (reset),
      .inc_i (we),
      .ptr_o (wAddr)
   );

   fifo_ptr #(.AW(AW)) u_head (
      .clk   (clk),
      .reset (reset),
      .inc_i (re),
      .ptr_o (rAddr)
   );

   always_comb begin
      count_d = count_q;
      case ({we, re})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Next status state: outcome of this cycle's request, seen next cycle.
   always_comb begin
      state_d  = NO_OP;
      wr_ack_d = 1'b0;
      wr_err_d = 1'b0;
      rd_ack_d = 1'b0;
      rd_err_d = 1'b0;
      if (both) begin
`ifdef FIFO_SIMUL_RW_EN
         if (empty)     state_d = WRITE;
         else if (full) state_d = READ;
         else           state_d = RW;
`else
         state_d = NO_OP;
`endif
      end else if (wr_en) begin
         state_d = full ? WR_ERR : WRITE;
      end else if (rd_en) begin
         state_d = empty ? RD_ERR : READ;
      end
      case (state_d)
         WRITE:  wr_ack_d = 1'b1;
         WR_ERR: wr_err_d = 1'b1;
         READ:   rd_ack_d = 1'b1;
         RD_ERR: rd_err_d = 1'b1;
`ifdef FIFO_SIMUL_RW_EN
         RW: begin
            wr_ack_d = 1'b1;
            rd_ack_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= INIT;
         count_q  <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
      end
   end

   assign data_count = count_q;
   assign wr_ack     = wr_ack_q;
   assign wr_err     = wr_err_q;
   assign rd_ack     = rd_ack_q;
   assign rd_err     = rd_err_q;

endmodule : fifo_ctrl
